// File: rtl/call_ctrl_ui_pkg.sv
// Shared encodings for the telephone UI controller: FSM states, application
// event/command codes, per-line status codes and menu item indices.
package call_ui_pkg;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_MENU     = 3'd2;
    localparam logic [2:0] ST_DIAL     = 3'd3;
    localparam logic [2:0] ST_OUTGOING = 3'd4;
    localparam logic [2:0] ST_INCOMING = 3'd5;
    localparam logic [2:0] ST_BUSY     = 3'd6;
    localparam logic [2:0] ST_WAIT_END = 3'd7;

    localparam logic [2:0] INC_CONNECTED = 3'd1;
    localparam logic [2:0] INC_INCOMING  = 3'd5;
    localparam logic [2:0] INC_ENDED     = 3'd6;

    localparam logic [2:0] CMD_DIAL      = 3'd1;
    localparam logic [2:0] CMD_ACCEPT    = 3'd2;
    localparam logic [2:0] CMD_END       = 3'd3;
    localparam logic [2:0] CMD_HOLD      = 3'd4;
    localparam logic [2:0] CMD_RESUME    = 3'd5;
    localparam logic [2:0] CMD_VOICEMAIL = 3'd6;

    localparam logic [1:0] LS_FREE      = 2'd0;
    localparam logic [1:0] LS_RINGING   = 2'd1;
    localparam logic [1:0] LS_CONNECTED = 2'd2;
    localparam logic [1:0] LS_HELD      = 2'd3;

    localparam logic [1:0] MI_CALL      = 2'd0;
    localparam logic [1:0] MI_VOICEMAIL = 2'd1;
    localparam logic [1:0] MI_ACCEPT    = 2'd1;
    localparam logic [1:0] MI_REJECT    = 2'd2;
    localparam logic [1:0] MI_HOLD_SWAP = 2'd1;
    localparam logic [1:0] MI_END       = 2'd2;

    // down advances, up retreats, both wrap over n items
    function automatic logic [1:0] menu_step(input logic [1:0] item, input logic dn,
                                             input logic [1:0] n);
        if (dn) return (item == n - 2'd1) ? 2'd0 : item + 2'd1;
        return (item == 2'd0) ? n - 2'd1 : item - 2'd1;
    endfunction

endpackage

// File: rtl/call_ctrl_ui_dial_buffer.sv
// Dial digit store: push/backspace at the tail while dialling, drained from
// the head over a valid/ready stream once the call is placed.
module dial_buffer #(
    parameter int MAX_DIGITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [3:0] digit_i,
    input  logic       drain_en_i,
    input  logic       dial_ready_i,
    output logic       dial_valid_o,
    output logic [3:0] dial_digit_o,
    output logic [3:0] count_o,
    output logic       full_o
);
    logic [MAX_DIGITS-1:0][3:0] mem_q, mem_d;
    logic [3:0]                 cnt_q, cnt_d;

    assign full_o       = (cnt_q == 4'(MAX_DIGITS));
    assign count_o      = cnt_q;
    assign dial_valid_o = drain_en_i && (cnt_q != 4'd0);
    assign dial_digit_o = mem_q[0];

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (dial_valid_o && dial_ready_i) begin
            for (int i = 0; i < MAX_DIGITS - 1; i++) mem_d[i] = mem_q[i+1];
            cnt_d = cnt_q - 4'd1;
        end else if (push_i && !full_o) begin
            mem_d[cnt_q] = digit_i;
            cnt_d        = cnt_q + 4'd1;
        end else if (pop_i && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
            cnt_q <= 4'd0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/call_ctrl_ui.sv
// Multi-line telephone UI controller: button/menu FSM, per-line call state,
// two-deep command queue to the application layer and dial digit streaming.
module call_ctrl_ui
    import call_ui_pkg::*;
#(
    parameter int NUM_LINES    = 2,
    parameter int MAX_DIGITS   = 10,
    parameter int RING_TIMEOUT = 50_000_000,
    parameter int LINE_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enter,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic [3:0]             digit,
    input  logic                   digit_strobe,
    input  logic                   inc_valid,
    input  logic [2:0]             inc_command,
    input  logic [LINE_W-1:0]      inc_line,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [2:0]             command,
    output logic [LINE_W-1:0]      cmd_line,
    output logic                   dial_valid,
    input  logic                   dial_ready,
    output logic [3:0]             dial_digit,
    output logic [2:0]             current_state,
    output logic [1:0]             current_menu_item,
    output logic [LINE_W-1:0]      active_line,
    output logic [2*NUM_LINES-1:0] line_status,
    output logic [3:0]             digit_count,
    output logic                   voicemail_command,
    output logic                   error
);
    localparam int LN = 1 << LINE_W;
    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam logic [RW-1:0]   RING_LAST = RW'(RING_TIMEOUT - 1);
    localparam logic [LINE_W:0] NL        = (LINE_W + 1)'(NUM_LINES);

    logic [2:0]             state_q, state_d;
    logic [1:0]             menu_q, menu_d;
    logic [LINE_W-1:0]      act_q, act_d;
    logic [LN-1:0][1:0]     lst_q, lst_d;
    logic [RW-1:0]          ring_q, ring_d;
    logic                   err_q, err_d, vm_q, vm_d, stream_q, stream_d;
    logic                   cv_q, cv_d, pv_q, pv_d;
    logic [2:0]             cop_q, cop_d, pop_q, pop_d;
    logic [LINE_W-1:0]      cln_q, cln_d, pln_q, pln_d;
    logic [1:0]             iss_v;
    logic [1:0][2:0]        iss_op;
    logic [1:0][LINE_W-1:0] iss_ln;
    logic                   buf_push, buf_pop, buf_clr, buf_full;
    logic                   ev, btn, any_free, any_held;
    logic [LINE_W-1:0]      free_ln, held_ln;

    assign ev  = inc_valid && ({1'b0, inc_line} < NL) &&
                 (inc_command == INC_CONNECTED || inc_command == INC_INCOMING ||
                  inc_command == INC_ENDED);
    assign btn = enter | up | down | left | right;

    // Lowest FREE line, and lowest HELD line other than the active one
    always_comb begin
        any_free = 1'b0; free_ln = '0; any_held = 1'b0; held_ln = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (lst_q[i] == LS_FREE) begin any_free = 1'b1; free_ln = LINE_W'(i); end
            if (lst_q[i] == LS_HELD && LINE_W'(i) != act_q) begin
                any_held = 1'b1; held_ln = LINE_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q; menu_d = menu_q; act_d = act_q; lst_d = lst_q;
        err_d = 1'b0; vm_d = 1'b0; stream_d = stream_q;
        buf_push = 1'b0; buf_pop = 1'b0; buf_clr = 1'b0;
        iss_v = '0; iss_op = '0; iss_ln = '0;
        if (ev) begin
            if (inc_command == INC_CONNECTED) begin
                if (state_q == ST_OUTGOING && inc_line == act_q) begin
                    lst_d[inc_line] = LS_CONNECTED; state_d = ST_BUSY;
                end
            end else if (inc_command == INC_INCOMING) begin
                if (state_q == ST_IDLE) begin
                    lst_d[inc_line] = LS_RINGING; act_d = inc_line; state_d = ST_INCOMING;
                end else if (state_q == ST_BUSY) begin
                    if (!any_free) begin
                        iss_v[0] = 1'b1; iss_op[0] = CMD_END; iss_ln[0] = inc_line;
                    end else if (inc_line != act_q) begin
                        iss_v[0] = 1'b1; iss_op[0] = CMD_HOLD; iss_ln[0] = act_q;
                        lst_d[act_q] = LS_HELD; lst_d[inc_line] = LS_RINGING;
                        act_d = inc_line; state_d = ST_INCOMING;
                    end
                end
            end else begin
                lst_d[inc_line] = LS_FREE;
                // Far end hung up on the call we own: fall back to a held call
                if (inc_line == act_q && state_q >= ST_OUTGOING) begin
                    buf_clr = 1'b1;
                    if (any_held) begin
                        iss_v[0] = 1'b1; iss_op[0] = CMD_RESUME; iss_ln[0] = held_ln;
                        lst_d[held_ln] = LS_CONNECTED; act_d = held_ln; state_d = ST_BUSY;
                    end else state_d = ST_IDLE;
                end
            end
        end else if (state_q == ST_INCOMING && ring_q == RING_LAST) begin
            iss_v[0] = 1'b1; iss_op[0] = CMD_VOICEMAIL; iss_ln[0] = act_q;
            vm_d = 1'b1; lst_d[act_q] = LS_FREE;
            if (any_held) begin act_d = held_ln; state_d = ST_BUSY; end
            else state_d = ST_IDLE;
        end else if (btn) begin
            case (state_q)
                ST_INIT: if (enter) state_d = ST_IDLE;
                ST_IDLE: if (right) state_d = ST_MENU;
                ST_MENU:
                    if (up || down) menu_d = menu_step(menu_q, down, 2'd2);
                    else if (left) state_d = ST_IDLE;
                    else if (enter && menu_q == MI_CALL) begin
                        buf_clr = 1'b1; state_d = ST_DIAL;
                    end else if (enter && menu_q == MI_VOICEMAIL) begin
                        if (cv_q) err_d = 1'b1;
                        else begin
                            iss_v[0] = 1'b1; iss_op[0] = CMD_VOICEMAIL; iss_ln[0] = act_q;
                            vm_d = 1'b1;
                        end
                    end
                ST_DIAL:
                    if (left) begin
                        if (digit_count != 4'd0) buf_pop = 1'b1;
                        else state_d = ST_MENU;
                    end else if (enter && digit_count != 4'd0) begin
                        if (!any_free || cv_q) err_d = 1'b1;
                        else begin
                            iss_v[0] = 1'b1; iss_op[0] = CMD_DIAL; iss_ln[0] = free_ln;
                            act_d = free_ln; state_d = ST_OUTGOING;
                        end
                    end
                ST_OUTGOING:
                    if (enter) begin
                        if (cv_q) err_d = 1'b1;
                        else begin
                            iss_v[0] = 1'b1; iss_op[0] = CMD_END; iss_ln[0] = act_q;
                            buf_clr = 1'b1; state_d = ST_WAIT_END;
                        end
                    end
                ST_INCOMING:
                    if (up || down) menu_d = menu_step(menu_q, down, 2'd3);
                    else if (enter && (menu_q == MI_ACCEPT || menu_q == MI_REJECT)) begin
                        if (cv_q) err_d = 1'b1;
                        else if (menu_q == MI_ACCEPT) begin
                            iss_v[0] = 1'b1; iss_op[0] = CMD_ACCEPT; iss_ln[0] = act_q;
                            lst_d[act_q] = LS_CONNECTED; state_d = ST_BUSY;
                        end else begin
                            iss_v[0] = 1'b1; iss_op[0] = CMD_END; iss_ln[0] = act_q;
                            state_d = ST_WAIT_END;
                        end
                    end
                ST_BUSY:
                    if (up || down) menu_d = menu_step(menu_q, down, 2'd3);
                    else if (enter && (menu_q == MI_HOLD_SWAP || menu_q == MI_END)) begin
                        iss_v[0] = 1'b1; iss_ln[0] = act_q;
                        iss_op[0] = (menu_q == MI_END) ? CMD_END : CMD_HOLD;
                        if (cv_q) begin
                            err_d = 1'b1; iss_v = '0;
                        end else if (menu_q == MI_END) begin
                            state_d = ST_WAIT_END;
                        end else begin
                            lst_d[act_q] = LS_HELD;
                            if (any_held) begin
                                iss_v[1] = 1'b1; iss_op[1] = CMD_RESUME; iss_ln[1] = held_ln;
                                lst_d[held_ln] = LS_CONNECTED; act_d = held_ln;
                            end
                        end
                    end
                default: ;
            endcase
        end else if (digit_strobe && state_q == ST_DIAL) begin
            if (buf_full) err_d = 1'b1;
            else buf_push = 1'b1;
        end
        if (state_d != state_q) menu_d = 2'd0;
        ring_d = (state_q == ST_INCOMING && state_d == ST_INCOMING) ? ring_q + RW'(1) : '0;

        // Command queue: head slot drives the port, second slot backs HOLD+RESUME
        cv_d = cv_q; cop_d = cop_q; cln_d = cln_q;
        pv_d = pv_q; pop_d = pop_q; pln_d = pln_q;
        if (cv_q && cmd_ready) begin
            if (cop_q == CMD_DIAL) stream_d = 1'b1;
            cv_d = pv_q; cop_d = pop_q; cln_d = pln_q; pv_d = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (iss_v[k]) begin
                if (!cv_d) begin
                    cv_d = 1'b1; cop_d = iss_op[k]; cln_d = iss_ln[k];
                end else if (!pv_d) begin
                    pv_d = 1'b1; pop_d = iss_op[k]; pln_d = iss_ln[k];
                end
            end
        end
        if (buf_clr || (dial_valid && dial_ready && digit_count == 4'd1)) stream_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT; menu_q <= 2'd0; act_q <= '0; lst_q <= '0; ring_q <= '0;
            err_q <= 1'b0; vm_q <= 1'b0; stream_q <= 1'b0;
            cv_q <= 1'b0; cop_q <= 3'd0; cln_q <= '0;
            pv_q <= 1'b0; pop_q <= 3'd0; pln_q <= '0;
        end else begin
            state_q <= state_d; menu_q <= menu_d; act_q <= act_d; lst_q <= lst_d;
            ring_q <= ring_d; err_q <= err_d; vm_q <= vm_d; stream_q <= stream_d;
            cv_q <= cv_d; cop_q <= cop_d; cln_q <= cln_d;
            pv_q <= pv_d; pop_q <= pop_d; pln_q <= pln_d;
        end
    end

    dial_buffer #(.MAX_DIGITS(MAX_DIGITS)) u_buf (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (buf_clr),
        .push_i       (buf_push),
        .pop_i        (buf_pop),
        .digit_i      (digit),
        .drain_en_i   (stream_q),
        .dial_ready_i (dial_ready),
        .dial_valid_o (dial_valid),
        .dial_digit_o (dial_digit),
        .count_o      (digit_count),
        .full_o       (buf_full)
    );

    assign cmd_valid         = cv_q;
    assign command           = cop_q;
    assign cmd_line          = cln_q;
    assign current_state     = state_q;
    assign current_menu_item = menu_q;
    assign active_line       = act_q;
    assign line_status       = lst_q[NUM_LINES-1:0];
    assign voicemail_command = vm_q;
    assign error             = err_q;
endmodule

// File: tb/tb_call_ctrl_ui.sv
// Directed bench for call_ctrl_ui: 2 lines, 10-digit buffer, 20-cycle ring timeout.
module tb_call_ctrl_ui;
    localparam int LINE_W = 3;

    logic clk = 1'b0, reset = 1'b0;
    logic [4:0] btn = '0;  // 0 enter, 1 up, 2 down, 3 left, 4 right
    logic [3:0] digit = '0;
    logic digit_strobe = 1'b0, inc_valid = 1'b0, cmd_ready = 1'b0, dial_ready = 1'b0;
    logic [2:0] inc_command = '0;
    logic [LINE_W-1:0] inc_line = '0;
    logic cmd_valid, dial_valid, voicemail_command, error;
    logic [2:0] command, current_state;
    logic [LINE_W-1:0] cmd_line, active_line;
    logic [3:0] dial_digit, digit_count;
    logic [1:0] current_menu_item;
    logic [3:0] line_status;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    call_ctrl_ui #(.NUM_LINES(2), .MAX_DIGITS(10), .RING_TIMEOUT(20), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset),
        .enter(btn[0]), .up(btn[1]), .down(btn[2]), .left(btn[3]), .right(btn[4]),
        .digit(digit), .digit_strobe(digit_strobe),
        .inc_valid(inc_valid), .inc_command(inc_command), .inc_line(inc_line),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .command(command), .cmd_line(cmd_line),
        .dial_valid(dial_valid), .dial_ready(dial_ready), .dial_digit(dial_digit),
        .current_state(current_state), .current_menu_item(current_menu_item),
        .active_line(active_line), .line_status(line_status), .digit_count(digit_count),
        .voicemail_command(voicemail_command), .error(error)
    );

    // Stimulus helpers: each starts and ends at a falling edge
    task automatic press(input int b);
        btn[b] = 1'b1; @(negedge clk); btn = '0;
    endtask
    task automatic strobe(input logic [3:0] d);
        digit = d; digit_strobe = 1'b1; @(negedge clk); digit_strobe = 1'b0;
    endtask
    task automatic inc(input logic [2:0] c, input logic [LINE_W-1:0] l);
        inc_command = c; inc_line = l; inc_valid = 1'b1; @(negedge clk); inc_valid = 1'b0;
    endtask
    task automatic ack();
        cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
    endtask
    task automatic do_reset();
        btn = '0; digit_strobe = 0; inc_valid = 0; cmd_ready = 0; dial_ready = 0;
        reset = 1'b0; @(negedge clk); reset = 1'b1;
    endtask
    task automatic to_dial();
        do_reset(); press(0); press(4); press(0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (current_state !== 3'd0 || current_menu_item !== 2'd0) begin errors++;
            $display("FAIL reset_state: got st=%0d mi=%0d want 0/0", current_state, current_menu_item); end
        checks++; if (line_status !== 4'd0 || digit_count !== 4'd0 || cmd_valid !== 1'b0 ||
                      dial_valid !== 1'b0 || error !== 1'b0 || voicemail_command !== 1'b0) begin errors++;
            $display("FAIL reset_outputs: ls=%b cnt=%0d cv=%b dv=%b err=%b vm=%b want all 0",
                     line_status, digit_count, cmd_valid, dial_valid, error, voicemail_command); end
        reset = 1'b1;
    endtask

    task automatic test_outgoing();
        logic [3:0] exp [3] = '{4'd4, 4'd1, 4'd5};
        press(0);
        checks++; if (current_state !== 3'd1) begin errors++;
            $display("FAIL init_enter: got %0d want 1", current_state); end
        press(4); press(0);
        checks++; if (current_state !== 3'd3) begin errors++;
            $display("FAIL menu_call: got %0d want 3", current_state); end
        strobe(4); strobe(1); strobe(5); press(0);
        checks++; if (current_state !== 3'd4 || cmd_valid !== 1'b1 || command !== 3'd1 ||
                      cmd_line !== 3'd0 || dial_valid !== 1'b0) begin errors++;
            $display("FAIL dial_cmd: st=%0d cv=%b cmd=%0d ln=%0d dv=%b want 4/1/1/0/0",
                     current_state, cmd_valid, command, cmd_line, dial_valid); end
        ack();
        for (int k = 0; k < 3; k++) begin
            checks++; if (dial_valid !== 1'b1 || dial_digit !== exp[k]) begin errors++;
                $display("FAIL stream_%0d: dv=%b digit=%0d want 1/%0d", k, dial_valid, dial_digit, exp[k]); end
            dial_ready = 1'b1; @(negedge clk); dial_ready = 1'b0;
        end
        checks++; if (dial_valid !== 1'b0 || digit_count !== 4'd0 || cmd_valid !== 1'b0) begin errors++;
            $display("FAIL stream_done: dv=%b cnt=%0d cv=%b want 0/0/0", dial_valid, digit_count, cmd_valid); end
        inc(3'd1, 3'd0);
        checks++; if (current_state !== 3'd6 || line_status !== 4'b0010) begin errors++;
            $display("FAIL connected: st=%0d ls=%b want 6/0010", current_state, line_status); end
    endtask

    task automatic test_menu_voicemail();
        do_reset(); press(0); press(4);
        press(2); press(2);
        checks++; if (current_menu_item !== 2'd0) begin errors++;
            $display("FAIL menu_wrap_down: got %0d want 0", current_menu_item); end
        press(1);
        checks++; if (current_menu_item !== 2'd1) begin errors++;
            $display("FAIL menu_wrap_up: got %0d want 1", current_menu_item); end
        press(0);
        checks++; if (voicemail_command !== 1'b1 || cmd_valid !== 1'b1 || command !== 3'd6 ||
                      current_state !== 3'd2) begin errors++;
            $display("FAIL menu_vm: vm=%b cv=%b cmd=%0d st=%0d want 1/1/6/2",
                     voicemail_command, cmd_valid, command, current_state); end
        @(negedge clk);
        checks++; if (voicemail_command !== 1'b0) begin errors++;
            $display("FAIL menu_vm_pulse: got %b want 0", voicemail_command); end
        press(3);
        checks++; if (current_state !== 3'd1) begin errors++;
            $display("FAIL menu_left: got %0d want 1", current_state); end
    endtask

    task automatic test_overflow();
        int errs = 0;
        to_dial();
        for (int i = 0; i < 11; i++) begin
            strobe(4'(i % 10));
            if (error === 1'b1) errs++;
        end
        checks++; if (digit_count !== 4'd10 || errs != 1) begin errors++;
            $display("FAIL overflow: cnt=%0d err_pulses=%0d want 10/1", digit_count, errs); end
        repeat (10) press(3);
        checks++; if (digit_count !== 4'd0 || current_state !== 3'd3) begin errors++;
            $display("FAIL backspace_all: cnt=%0d st=%0d want 0/3", digit_count, current_state); end
        press(3);
        checks++; if (current_state !== 3'd2) begin errors++;
            $display("FAIL left_empty: got %0d want 2", current_state); end
    endtask

    task automatic test_backspace();
        to_dial();
        press(0);
        checks++; if (current_state !== 3'd3 || cmd_valid !== 1'b0) begin errors++;
            $display("FAIL enter_empty: st=%0d cv=%b want 3/0", current_state, cmd_valid); end
        strobe(7); strobe(8); strobe(9); press(3);
        checks++; if (digit_count !== 4'd2) begin errors++;
            $display("FAIL pop: got %0d want 2", digit_count); end
        press(0); ack();
        checks++; if (dial_digit !== 4'd7) begin errors++;
            $display("FAIL pop_stream0: got %0d want 7", dial_digit); end
        dial_ready = 1'b1; @(negedge clk); dial_ready = 1'b0;
        checks++; if (dial_digit !== 4'd8 || dial_valid !== 1'b1) begin errors++;
            $display("FAIL pop_stream1: digit=%0d dv=%b want 8/1", dial_digit, dial_valid); end
    endtask

    task automatic test_call_waiting();
        do_reset(); press(0); inc(3'd5, 3'd0);
        press(2); press(0);
        checks++; if (command !== 3'd2 || cmd_line !== 3'd0 || current_state !== 3'd6 ||
                      line_status !== 4'b0010) begin errors++;
            $display("FAIL accept0: cmd=%0d ln=%0d st=%0d ls=%b want 2/0/6/0010",
                     command, cmd_line, current_state, line_status); end
        ack(); inc(3'd5, 3'd1);
        checks++; if (command !== 3'd4 || cmd_line !== 3'd0 || line_status !== 4'b0111 ||
                      current_state !== 3'd5 || active_line !== 3'd1) begin errors++;
            $display("FAIL cw_hold: cmd=%0d ln=%0d ls=%b st=%0d act=%0d want 4/0/0111/5/1",
                     command, cmd_line, line_status, current_state, active_line); end
        ack(); press(2); press(0);
        checks++; if (command !== 3'd2 || cmd_line !== 3'd1 || line_status !== 4'b1011) begin errors++;
            $display("FAIL cw_accept: cmd=%0d ln=%0d ls=%b want 2/1/1011", command, cmd_line, line_status); end
        ack(); press(2); press(2); press(0);
        checks++; if (command !== 3'd3 || cmd_line !== 3'd1 || current_state !== 3'd7) begin errors++;
            $display("FAIL cw_end: cmd=%0d ln=%0d st=%0d want 3/1/7", command, cmd_line, current_state); end
        ack(); inc(3'd6, 3'd1);
        checks++; if (command !== 3'd5 || cmd_line !== 3'd0 || current_state !== 3'd6 ||
                      active_line !== 3'd0 || line_status !== 4'b0010) begin errors++;
            $display("FAIL cw_resume: cmd=%0d ln=%0d st=%0d act=%0d ls=%b want 5/0/6/0/0010",
                     command, cmd_line, current_state, active_line, line_status); end
        ack();
    endtask

    task automatic test_no_free_line();
        inc(3'd5, 3'd1); ack(); press(2); press(0); ack();
        inc(3'd5, 3'd0);
        checks++; if (cmd_valid !== 1'b1 || command !== 3'd3 || cmd_line !== 3'd0 ||
                      current_state !== 3'd6 || line_status !== 4'b1011) begin errors++;
            $display("FAIL auto_end: cv=%b cmd=%0d ln=%0d st=%0d ls=%b want 1/3/0/6/1011",
                     cmd_valid, command, cmd_line, current_state, line_status); end
        press(2); press(0);
        checks++; if (error !== 1'b1 || command !== 3'd3 || cmd_line !== 3'd0 ||
                      line_status !== 4'b1011) begin errors++;
            $display("FAIL busy_error: err=%b cmd=%0d ln=%0d ls=%b want 1/3/0/1011",
                     error, command, cmd_line, line_status); end
        ack(); press(0);
        checks++; if (command !== 3'd4 || cmd_line !== 3'd1 || line_status !== 4'b1110 ||
                      active_line !== 3'd0 || error !== 1'b0) begin errors++;
            $display("FAIL swap_hold: cmd=%0d ln=%0d ls=%b act=%0d err=%b want 4/1/1110/0/0",
                     command, cmd_line, line_status, active_line, error); end
        ack();
        checks++; if (cmd_valid !== 1'b1 || command !== 3'd5 || cmd_line !== 3'd0) begin errors++;
            $display("FAIL swap_resume: cv=%b cmd=%0d ln=%0d want 1/5/0", cmd_valid, command, cmd_line); end
        ack();
    endtask

    task automatic test_ring_timeout();
        int first = -1, pulses = 0;
        logic [2:0] st19 = '0;
        do_reset(); press(0); inc(3'd5, 3'd1);
        checks++; if (current_state !== 3'd5 || line_status !== 4'b0100) begin errors++;
            $display("FAIL ring_enter: st=%0d ls=%b want 5/0100", current_state, line_status); end
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 19) st19 = current_state;
            if (voicemail_command === 1'b1) begin pulses++; if (first < 0) first = c; end
        end
        checks++; if (first != 20 || pulses != 1 || st19 !== 3'd5) begin errors++;
            $display("FAIL ring_timing: first=%0d pulses=%0d st@19=%0d want 20/1/5", first, pulses, st19); end
        checks++; if (current_state !== 3'd1 || cmd_valid !== 1'b1 || command !== 3'd6 ||
                      cmd_line !== 3'd1 || line_status !== 4'd0) begin errors++;
            $display("FAIL ring_divert: st=%0d cv=%b cmd=%0d ln=%0d ls=%b want 1/1/6/1/0000",
                     current_state, cmd_valid, command, cmd_line, line_status); end
    endtask

    task automatic test_reset_midstream();
        to_dial(); strobe(3); strobe(5); strobe(7); press(0); ack();
        dial_ready = 1'b1; @(negedge clk); dial_ready = 1'b0;
        inc(3'd1, 3'd0);
        checks++; if (dial_valid !== 1'b1 || dial_digit !== 4'd5 || line_status !== 4'b0010) begin errors++;
            $display("FAIL pre_reset: dv=%b digit=%0d ls=%b want 1/5/0010", dial_valid, dial_digit, line_status); end
        reset = 1'b0; #1;
        checks++; if (dial_valid !== 1'b0 || current_state !== 3'd0 || line_status !== 4'd0 ||
                      cmd_valid !== 1'b0 || digit_count !== 4'd0) begin errors++;
            $display("FAIL async_reset: dv=%b st=%0d ls=%b cv=%b cnt=%0d want 0/0/0000/0/0",
                     dial_valid, current_state, line_status, cmd_valid, digit_count); end
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_outgoing();
        test_menu_voicemail();
        test_overflow();
        test_backspace();
        test_call_waiting();
        test_no_free_line();
        test_ring_timeout();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
